load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/load_extend.sv | 34 +++
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_pkg : func3 encodings, FSM state type and access-check helper    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ACCESS    = 2'd1,
      ST_LOAD_WAIT = 2'd2,
      ST_RESP      = 2'd3
   } lsu_state_e;

   // Returns 1 when the request must be refused (illegal width or misaligned).
   function automatic logic access_fault(input logic       is_store,
                                         input logic [2:0] func3,
                                         input logic [1:0] addr_lo);
      logic fault;
      fault = 1'b0;
      case (func3)
         F3_B:    fault = 1'b0;
         F3_H:    fault = addr_lo[0];
         F3_W:    fault = (addr_lo != 2'b00);
         F3_BU:   fault = is_store;
         F3_HU:   fault = is_store | addr_lo[0];
         default: fault = 1'b1;
      endcase
      return fault;
   endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// +----------------------------------------------------------------------+
// | load_extend : selects the addressed byte/halfword and extends it     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  byte_off,
   input  logic [2:0]  func3,
   output logic [31:0] ext_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{byte_off, 3'b000} +: 8];
      half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
      case (func3)
         F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   ext_data = {24'd0, byte_sel};
         F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   ext_data = {16'd0, half_sel};
         F3_W:    ext_data = rdata;
         default: ext_data = 32'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------+
// | load_store_unit : single-outstanding RV32 load/store to data memory  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_func3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata
);

   lsu_state_e  state_q, state_d;
   logic [2:0]  func3_q, func3_d;
   logic [1:0]  off_q, off_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [31:0] ld_data;

   load_extend u_load_extend (
      .rdata    (mem_rdata),
      .byte_off (off_q),
      .func3    (func3_q),
      .ext_data (ld_data)
   );

   // Store data is replicated across lanes so memory only needs the strobes.
   always_comb begin
      st_wdata = req_wdata;
      st_wstrb = 4'b1111;
      case (req_func3)
         F3_B: begin
            st_wdata = {4{req_wdata[7:0]}};
            st_wstrb = 4'b0001 << req_addr[1:0];
         end
         F3_H: begin
            st_wdata = {2{req_wdata[15:0]}};
            st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      func3_d      = func3_q;
      off_d        = off_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wstrb_d  = mem_wstrb_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (access_fault(req_write, req_func3, req_addr[1:0])) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'd0;
               end else begin
                  state_d     = ST_ACCESS;
                  func3_d     = req_func3;
                  off_d       = req_addr[1:0];
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_read_d  = ~req_write;
                  mem_write_d = req_write;
                  mem_wdata_d = req_write ? st_wdata : 32'd0;
                  mem_wstrb_d = req_write ? st_wstrb : 4'b0000;
               end
            end
         end
         ST_ACCESS: begin
            if (mem_write_q) begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = 32'd0;
            end else begin
               state_d = ST_LOAD_WAIT;
            end
         end
         ST_LOAD_WAIT: begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = ld_data;
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = 32'd0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         func3_q      <= 3'd0;
         off_q        <= 2'd0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         mem_wstrb_q  <= 4'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         func3_q      <= func3_d;
         off_q        <= off_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wstrb_q  <= mem_wstrb_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE) && !reset;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wstrb  = mem_wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +----------------------------------------------------------------------+
// | tb_load_store_unit : directed bench with transaction-level model     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_func3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   logic [31:0] mem [16];

   int n_checks = 0;
   int n_errs   = 0;

   load_store_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_func3  (req_func3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Read data is only meaningful the cycle after mem_read; otherwise garbage.
   always @(posedge clk)
      mem_rdata <= mem_read ? mem[mem_addr[5:2]] : 32'hDEAD_BEEF;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] w,
                                          input logic [1:0] off);
      logic [31:0] b, h;
      b = (w >> (off * 8)) & 32'hFF;
      h = (w >> (off[1] * 16)) & 32'hFFFF;
      case (f3)
         3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
         3'd4:    return b;
         3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   // Transaction model: cycles since acceptance decide what is visible.
   bit          m_init = 0, m_busy = 0, m_clean = 1, m_w = 0, m_err = 0;
   int          m_age = 0, m_lat = 0;
   logic [31:0] m_rdata, m_addr, m_wdata;
   logic [3:0]  m_wstrb;

   always @(posedge clk) begin : model
      logic [2:0]  f3;
      logic [31:0] a, wd;
      m_init = 1;
      if (reset) begin
         m_busy  = 0;
         m_clean = 1;
      end else if (!m_busy) begin
         if (req_valid) begin
            f3 = req_func3; a = req_addr; wd = req_wdata; m_w = req_write;
            m_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (m_w && f3[2]) ||
                    (((f3 == 3'd1) || (f3 == 3'd5)) && a[0]) ||
                    ((f3 == 3'd2) && (a[1:0] != 2'b00));
            m_lat   = m_err ? 1 : (m_w ? 2 : 3);
            m_addr  = a & 32'hFFFF_FFFC;
            m_wdata = wd;
            m_wstrb = 4'hF;
            if (f3 == 3'd0) begin
               m_wdata = {4{wd[7:0]}};
               m_wstrb = 4'b0001 << a[1:0];
            end else if (f3 == 3'd1) begin
               m_wdata = {2{wd[15:0]}};
               m_wstrb = a[1] ? 4'hC : 4'h3;
            end
            m_rdata = (m_err || m_w) ? 32'd0 : f_load(f3, mem[a[5:2]], a[1:0]);
            m_busy  = 1;
            m_clean = 0;
            m_age   = 1;
         end
      end else if (m_age >= m_lat && resp_ready) begin
         m_busy = 0;
      end else begin
         m_age++;
      end
   end

   always @(negedge clk) begin : compare
      bit exp_rv, exp_acc;
      if (m_init) begin
         exp_rv  = m_busy && (m_age >= m_lat);
         exp_acc = m_busy && !m_err && (m_age == 1);
         chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy && !reset});
         chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_rv});
         chk("mem_read", {31'd0, mem_read}, {31'd0, exp_acc && !m_w});
         chk("mem_write", {31'd0, mem_write}, {31'd0, exp_acc && m_w});
         if (exp_rv) begin
            chk("resp_rdata", resp_rdata, m_rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
         end
         if (exp_acc) begin
            chk("mem_addr", mem_addr, m_addr);
            if (m_w) begin
               chk("mem_wdata", mem_wdata, m_wdata);
               chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m_wstrb});
            end
         end
         if (m_clean) begin
            chk("clean_mem_addr", mem_addr, 32'd0);
            chk("clean_mem_wdata", mem_wdata, 32'd0);
            chk("clean_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
            chk("clean_resp_rdata", resp_rdata, 32'd0);
            chk("clean_resp_err", {31'd0, resp_err}, 32'd0);
         end
      end
   end

   task automatic wait_accept(output bit ok);
      int n = 0;
      ok = 0;
      while (!ok && n < 20) begin
         @(negedge clk);
         ok = req_ready;
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a, wd,
                        input logic [31:0] e_rdata, input bit e_err, input int e_lat,
                        input logic [31:0] e_maddr, e_mwdata, input logic [3:0] e_wstrb,
                        input int hold, input string nm);
      bit ok, seen;
      int lat;
      logic [31:0] cap_a, cap_d;
      logic [3:0]  cap_s;
      req_valid = 1; req_write = w; req_func3 = f3; req_addr = a; req_wdata = wd;
      resp_ready = (hold == 0);
      wait_accept(ok);
      chk({nm, "_accept"}, {31'd0, ok}, 32'd1);
      if (!ok) begin
         req_valid = 0;
         return;
      end
      // Keep presenting junk requests while busy; they must be ignored.
      req_write = 1'($urandom); req_func3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      lat = 0; seen = 0;
      while (!seen && lat < 8) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            cap_a = mem_addr; cap_d = mem_wdata; cap_s = mem_wstrb;
         end
         seen = resp_valid;
      end
      chk({nm, "_lat"}, lat, e_lat);
      if (seen) begin
         chk({nm, "_rdata"}, resp_rdata, e_rdata);
         chk({nm, "_err"}, {31'd0, resp_err}, {31'd0, e_err});
         if (!e_err) chk({nm, "_maddr"}, cap_a, e_maddr);
         if (w && !e_err) begin
            chk({nm, "_mwdata"}, cap_d, e_mwdata);
            chk({nm, "_wstrb"}, {28'd0, cap_s}, {28'd0, e_wstrb});
         end
      end
      repeat (hold) @(posedge clk);
      #1 resp_ready = 1;
      @(posedge clk); #1;
      req_valid = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      for (int i = 0; i < 16; i++) mem[i] = 32'h1357_9B00 | i;
      mem[1] = 32'hFF00_FF00;
      mem[3] = 32'h8234_7F56;
      reset = 1; req_valid = 0; req_write = 0; req_func3 = 0;
      req_addr = 0; req_wdata = 0; resp_ready = 1;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;

      //    w  f3    addr          wdata          rdata          err lat maddr          mwdata         wstrb hold
      issue(1, 3'd2, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0000_0000, 0, 2, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 0, "sw8");
      issue(1, 3'd0, 32'h0000_0015, 32'hABCD_EDEF, 32'h0000_0000, 0, 2, 32'h0000_0014, 32'hEFEF_EFEF, 4'h2, 0, "sb15");
      issue(0, 3'd0, 32'h0000_0005, 32'h0,         32'hFFFF_FFFF, 0, 3, 32'h0000_0004, 32'h0,         4'h0, 0, "lb5");
      issue(0, 3'd4, 32'h0000_0005, 32'h0,         32'h0000_00FF, 0, 3, 32'h0000_0004, 32'h0,         4'h0, 0, "lbu5");
      issue(0, 3'd1, 32'h0000_0006, 32'h0,         32'hFFFF_FF00, 0, 3, 32'h0000_0004, 32'h0,         4'h0, 0, "lh6");
      issue(0, 3'd2, 32'h0000_0004, 32'h0,         32'hFF00_FF00, 0, 3, 32'h0000_0004, 32'h0,         4'h0, 0, "lw4");
      issue(1, 3'd1, 32'h0000_0019, 32'h1234_5678, 32'h0000_0000, 1, 1, 32'h0,         32'h0,         4'h0, 0, "sh19");
      issue(0, 3'd2, 32'h0000_000E, 32'h0,         32'h0000_0000, 1, 1, 32'h0,         32'h0,         4'h0, 0, "lw0e");
      issue(0, 3'd5, 32'h0000_000E, 32'h0,         32'h0000_8234, 0, 3, 32'h0000_000C, 32'h0,         4'h0, 0, "lhu0e");
      issue(0, 3'd0, 32'h0000_000C, 32'h0,         32'h0000_0056, 0, 3, 32'h0000_000C, 32'h0,         4'h0, 0, "lb0c");
      issue(0, 3'd0, 32'h0000_000F, 32'h0,         32'hFFFF_FF82, 0, 3, 32'h0000_000C, 32'h0,         4'h0, 0, "lb0f");
      issue(1, 3'd1, 32'h0000_001A, 32'h1234_BEEF, 32'h0000_0000, 0, 2, 32'h0000_0018, 32'hBEEF_BEEF, 4'hC, 0, "sh1a");
      issue(0, 3'd3, 32'h0000_0000, 32'h0,         32'h0000_0000, 1, 1, 32'h0,         32'h0,         4'h0, 0, "ld_f3_3");
      issue(1, 3'd4, 32'h0000_0000, 32'h0,         32'h0000_0000, 1, 1, 32'h0,         32'h0,         4'h0, 0, "st_f3_4");
      issue(0, 3'd2, 32'h0000_0004, 32'h0,         32'hFF00_FF00, 0, 3, 32'h0000_0004, 32'h0,         4'h0, 4, "lw_hold");

      // Abort a load in LOAD_WAIT with reset.
      req_valid = 1; req_write = 0; req_func3 = 3'd2; req_addr = 32'h4;
      wait_accept(ok);
      chk("abort_accept", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
      reset = 1; req_valid = 0;
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("abort_mem_read", {31'd0, mem_read}, 32'd0);
      chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      issue(0, 3'd4, 32'h0000_000D, 32'h0, 32'h0000_007F, 0, 3, 32'h0000_000C, 32'h0, 4'h0, 0, "lbu0d");

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
